// File: rtl/bfly_out_serializer.sv
// Output sequencer for one radix-2 butterfly stage: sums pass straight through,
// differences are buffered and replayed as one gapless burst after the last sum.
module bfly_out_serializer #(
  parameter int NUM   = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sum_re,
  input  logic [WIDTH-1:0] in_sum_im,
  input  logic [WIDTH-1:0] in_diff_re,
  input  logic [WIDTH-1:0] in_diff_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_half,
  output logic             out_last,
  output logic             err_overrun,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(NUM);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_re_q, out_re_d;
  logic [WIDTH-1:0]    out_im_q, out_im_d;
  logic                out_half_q, out_half_d;
  logic                out_last_q, out_last_d;
  logic                err_overrun_q, err_overrun_d;

  logic [2*WIDTH-1:0]  buf_q [NUM];
  logic                buf_we;
  logic [2*WIDTH-1:0]  buf_wdata;
  logic [2*WIDTH-1:0]  buf_rdata;

  // State register; the buffer itself is not reset since its contents are don't-care.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_re_q      <= '0;
      out_im_q      <= '0;
      out_half_q    <= 1'b0;
      out_last_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_re_q      <= out_re_d;
      out_im_q      <= out_im_d;
      out_half_q    <= out_half_d;
      out_last_q    <= out_last_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Writes only happen in IDLE/PASS and reads only in DRAIN, so ports never collide.
  always_ff @(posedge clk) begin
    if (rst && buf_we) begin
      buf_q[cnt_q] <= buf_wdata;
    end
  end

  assign buf_rdata = buf_q[cnt_q];

  // Next-state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_PASS;
          cnt_d   = CW'(1);
        end
      end
      S_PASS: begin
        if (in_valid) begin
          if (cnt_q == CNT_MAX) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered-output values and buffer write request.
  always_comb begin
    out_valid_d   = 1'b0;
    out_re_d      = '0;
    out_im_d      = '0;
    out_half_d    = 1'b0;
    out_last_d    = 1'b0;
    err_overrun_d = err_overrun_q;
    buf_we        = 1'b0;
    buf_wdata     = {in_diff_re, in_diff_im};
    case (state_q)
      S_IDLE, S_PASS: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          out_re_d    = in_sum_re;
          out_im_d    = in_sum_im;
          buf_we      = 1'b1;
        end
      end
      S_DRAIN: begin
        out_valid_d          = 1'b1;
        {out_re_d, out_im_d} = buf_rdata;
        out_half_d           = 1'b1;
        out_last_d           = (cnt_q == CNT_MAX);
        // A sample arriving mid-burst has nowhere to go: drop it and flag it.
        if (in_valid) begin
          err_overrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_valid   = out_valid_q;
  assign out_re      = out_re_q;
  assign out_im      = out_im_q;
  assign out_half    = out_half_q;
  assign out_last    = out_last_q;
  assign err_overrun = err_overrun_q;
  assign dbg_state   = state_q;

endmodule
